// File: rtl/satcom_pkg.sv
// Shared types and helpers for the satcom FSK transmit path.
package satcom_pkg;

    // Framer state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } frame_state_t;

    localparam int DATA_BITS = 8;

    // DAC code for zero amplitude: 0 in two's complement, half-range in offset binary
    function automatic int unsigned midscale_code(input int dac_w, input int offset_bin);
        return (offset_bin != 0) ? (32'd1 << (dac_w - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/satcom_sine_lut.sv
// Full-wave sine lookup built from a quarter-wave ROM with quadrant folding.
// One registered stage; output only updates when en is high.
module satcom_sine_lut #(
    parameter int LUT_AW     = 10,
    parameter int DAC_W      = 16,
    parameter int OFFSET_BIN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-1:0]  sample
);
    import satcom_pkg::*;

    localparam int  QW  = LUT_AW - 2;
    localparam int  QN  = 1 << QW;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (DAC_W - 1)) - 1.0;
    localparam logic [DAC_W-1:0] MID = DAC_W'(midscale_code(DAC_W, OFFSET_BIN));

    // Quarter table holds QN+1 points so the peak (index QN) is exact when mirrored
    logic [DAC_W-1:0] rom [0:QN];

    genvar gi;
    generate
        for (gi = 0; gi <= QN; gi++) begin : g_rom
            localparam int VAL = $rtoi(AMP * $sin(2.0 * PI * real'(gi) / (2.0 ** LUT_AW)) + 0.5);
            assign rom[gi] = DAC_W'(VAL);
        end
    endgenerate

    logic [1:0]       quad;
    logic [QW-1:0]    idx;
    logic [QW:0]      rom_idx;
    logic [DAC_W-1:0] mag;
    logic [DAC_W-1:0] lut_val;

    // Fold the full-wave address onto the quarter table: mirror in quadrants 1/3, negate in 2/3
    always_comb begin
        quad    = addr[LUT_AW-1 -: 2];
        idx     = addr[QW-1:0];
        rom_idx = quad[0] ? ((QW+1)'(QN) - {1'b0, idx}) : {1'b0, idx};
        mag     = rom[rom_idx];
        lut_val = (quad[1] ? -mag : mag) ^ MID;
    end

    // Output register, loaded once per DAC sample
    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= MID;
        end else if (en) begin
            sample <= lut_val;
        end
    end

endmodule

// File: rtl/satcom_fsk_mod.sv
// UART byte to phase-continuous FSK tone transmitter with byte FIFO.
module satcom_fsk_mod #(
    parameter int SAMPLE_DIV = 1302,
    parameter int BAUD_DIV   = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    parameter int PHASE_W    = 24,
    parameter int MARK_INC   = 262144,
    parameter int SPACE_INC  = 480577,
    parameter int LUT_AW     = 10,
    parameter int DAC_W      = 16,
    parameter int OFFSET_BIN = 0
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic [7:0]       rbr,
    input  logic             rdrdy,
    input  logic             idle_mark,
    output logic             rdrst,
    output logic [DAC_W-1:0] dac_sample,
    output logic             dac_strobe,
    output logic             busy,
    output logic             fifo_full,
    output logic             overflow
);
    import satcom_pkg::*;

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int STOP_W = 1;

    // ---------------- sample tick ----------------
    logic [CNT_W-1:0] sample_cnt_reg;
    logic             tick;

    assign tick = (sample_cnt_reg == CNT_W'(SAMPLE_DIV - 1));

    // Free-running divider producing one tick per DAC sample period
    always_ff @(posedge clk_100M) begin
        if (rst || tick) begin
            sample_cnt_reg <= '0;
        end else begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
        end
    end

    // ---------------- UART handshake ----------------
    logic [2:0] rdrdy_sync_reg;
    logic       rdrdy_edge;
    logic [7:0] cap_byte_reg;
    logic       cap_valid_reg;
    logic [7:0] wr_byte_reg;
    logic       wr_valid_reg;
    logic       rdrst_reg;

    assign rdrdy_edge = rdrdy_sync_reg[1] & ~rdrdy_sync_reg[2];

    // Synchronise rdrdy, capture the byte on its rising edge and acknowledge it
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            rdrdy_sync_reg <= '0;
            cap_byte_reg   <= '0;
            cap_valid_reg  <= 1'b0;
            wr_byte_reg    <= '0;
            wr_valid_reg   <= 1'b0;
            rdrst_reg      <= 1'b0;
        end else begin
            rdrdy_sync_reg <= {rdrdy_sync_reg[1:0], rdrdy};
            cap_valid_reg  <= rdrdy_edge;
            rdrst_reg      <= rdrdy_edge;
            if (rdrdy_edge) begin
                cap_byte_reg <= rbr;
            end
            wr_valid_reg <= cap_valid_reg;
            wr_byte_reg  <= cap_byte_reg;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  fifo_rd_data_reg;
    logic        overflow_reg;
    logic        fifo_empty;
    logic        fifo_full_int;
    logic        wr_en;
    logic        pop;

    assign fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full_int = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Full is judged on the registered pointers, so a pop in the same cycle does not free a slot
    assign wr_en         = wr_valid_reg & ~fifo_full_int;

    // FIFO pointers and the sticky drop flag
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (wr_valid_reg && fifo_full_int) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

    // FIFO storage with registered read on pop
    always_ff @(posedge clk_100M) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= wr_byte_reg;
        end
        if (pop) begin
            fifo_rd_data_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
        end
    end

    // ---------------- framer ----------------
    frame_state_t      state_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [2:0]        data_idx_reg;
    logic [STOP_W-1:0] stop_idx_reg;
    logic [7:0]        shift_reg;
    logic              load_pend_reg;
    logic              bit_end;
    logic              last_stop;
    logic              line_bit;

    assign bit_end   = (bit_cnt_reg == BIT_W'(BAUD_DIV - 1));
    assign last_stop = (stop_idx_reg == STOP_W'(STOP_BITS - 1));
    assign pop       = tick & ~fifo_empty &
                       ((state_reg == IDLE) || ((state_reg == STOP) && bit_end && last_stop));

    // Line level for the bit currently on air
    always_comb begin
        line_bit = 1'b1;
        case (state_reg)
            IDLE:    line_bit = idle_mark;
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[0];
            STOP:    line_bit = 1'b1;
            default: line_bit = 1'b1;
        endcase
    end

    // Frame sequencing; the popped byte lands in the shift register two cycles after the pop,
    // well before the first data bit
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            data_idx_reg  <= '0;
            stop_idx_reg  <= '0;
            shift_reg     <= '0;
            load_pend_reg <= 1'b0;
        end else begin
            load_pend_reg <= pop;
            if (tick) begin
                bit_cnt_reg <= bit_end ? '0 : bit_cnt_reg + BIT_W'(1);
                case (state_reg)
                    IDLE: begin
                        bit_cnt_reg <= '0;
                        if (!fifo_empty) begin
                            state_reg <= START;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            state_reg    <= DATA;
                            data_idx_reg <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            if (data_idx_reg == 3'(DATA_BITS - 1)) begin
                                state_reg    <= STOP;
                                stop_idx_reg <= '0;
                            end else begin
                                data_idx_reg <= data_idx_reg + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (last_stop) begin
                                state_reg <= fifo_empty ? IDLE : START;
                            end else begin
                                stop_idx_reg <= stop_idx_reg + STOP_W'(1);
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
            if (load_pend_reg) begin
                shift_reg <= fifo_rd_data_reg;
            end
        end
    end

    // ---------------- NCO ----------------
    logic [PHASE_W-1:0] phase_reg;
    logic               tick_d1_reg;
    logic               strobe_reg;

    // Phase accumulator advances once per tick; silent idle parks it at zero
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            phase_reg   <= '0;
            tick_d1_reg <= 1'b0;
            strobe_reg  <= 1'b0;
        end else begin
            tick_d1_reg <= tick;
            strobe_reg  <= tick_d1_reg;
            if (tick) begin
                if ((state_reg == IDLE) && !idle_mark) begin
                    phase_reg <= '0;
                end else begin
                    phase_reg <= phase_reg + (line_bit ? PHASE_W'(MARK_INC) : PHASE_W'(SPACE_INC));
                end
            end
        end
    end

    satcom_sine_lut #(
        .LUT_AW     (LUT_AW),
        .DAC_W      (DAC_W),
        .OFFSET_BIN (OFFSET_BIN)
    ) u_sine_lut (
        .clk    (clk_100M),
        .rst    (rst),
        .en     (tick_d1_reg),
        .addr   (phase_reg[PHASE_W-1 -: LUT_AW]),
        .sample (dac_sample)
    );

    assign rdrst      = rdrst_reg;
    assign dac_strobe = strobe_reg;
    assign busy       = (state_reg != IDLE) | ~fifo_empty;
    assign fifo_full  = fifo_full_int;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_satcom_fsk_mod.sv
// Directed bench for satcom_fsk_mod with a small fast configuration.
module tb_satcom_fsk_mod;
    import satcom_pkg::*;

    localparam int MARK  = 262144;
    localparam int SPACE = 480577;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rbr = 8'h00;
    logic        rdrdy = 1'b0;
    logic        idle_mark = 1'b0;
    logic        rdrst;
    logic [15:0] dac_sample;
    logic        dac_strobe;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    logic [9:0]  lut_addr = '0;
    logic [15:0] lut_tc;
    logic [15:0] lut_ob;

    int tests = 0;
    int fails = 0;
    logic [23:0] model_phase = '0;
    bit frame_pending = 1'b0;

    always #5 clk = ~clk;

    satcom_fsk_mod #(
        .SAMPLE_DIV (4),
        .BAUD_DIV   (8),
        .FIFO_DEPTH (4),
        .STOP_BITS  (1)
    ) dut (
        .clk_100M   (clk),
        .rst        (rst),
        .rbr        (rbr),
        .rdrdy      (rdrdy),
        .idle_mark  (idle_mark),
        .rdrst      (rdrst),
        .dac_sample (dac_sample),
        .dac_strobe (dac_strobe),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    satcom_sine_lut #(.LUT_AW(10), .DAC_W(16), .OFFSET_BIN(0)) u_lut_tc (
        .clk(clk), .rst(rst), .en(1'b1), .addr(lut_addr), .sample(lut_tc)
    );

    satcom_sine_lut #(.LUT_AW(10), .DAC_W(16), .OFFSET_BIN(1)) u_lut_ob (
        .clk(clk), .rst(rst), .en(1'b1), .addr(lut_addr), .sample(lut_ob)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference sine: round-half-away of 32767*sin(2*pi*a/1024)
    function automatic logic [15:0] sine_ref(input int a);
        real s;
        int  r;
        s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * a / 1024.0);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(-s + 0.5);
        return 16'(r);
    endfunction

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dac_strobe && n < 16);
        if (!dac_strobe) check("strobe_timeout", 32'(dac_strobe), 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int lat = 0;
        int pulses = 0;
        @(negedge clk);
        rbr   = b;
        rdrdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rdrst) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        check("rdrst_lat", lat, 3);
        check("rdrst_pulses", pulses, 1);
        rdrdy = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Wait for the first START tick of a frame out of silent idle
    task automatic sync_frame();
        int n = 0;
        do begin
            wait_strobe();
            n++;
        end while (dut.phase_reg == 0 && n < 40);
        check("frame_start", 32'(dut.phase_reg != 0), 1);
        model_phase   = '0;
        frame_pending = 1'b1;
    endtask

    // Expect one frame's worth of ticks: start, 8 data LSB first, 1 stop, 8 ticks each
    task automatic expect_frame(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int t = 0; t < 8; t++) begin
                if (frame_pending) frame_pending = 1'b0;
                else               wait_strobe();
                model_phase = model_phase + (bits[k] ? 24'(MARK) : 24'(SPACE));
                check("phase", 32'(dut.phase_reg), 32'(model_phase));
                check("sample", 32'(dac_sample), 32'(sine_ref(int'(model_phase[23:14]))));
            end
        end
    endtask

    task automatic idle_check();
        wait_strobe();
        check("idle_phase", 32'(dut.phase_reg), 0);
        check("idle_sample", 32'(dac_sample), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int strobe_seen;
        logic [9:0]  pt_addr [4];
        logic [15:0] pt_tc   [4];
        logic [15:0] pt_ob   [4];
        pt_addr = '{10'd0, 10'd256, 10'd512, 10'd768};
        pt_tc   = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};
        pt_ob   = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0001};

        // 1: reset
        rst = 1'b1;
        strobe_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (dac_strobe) strobe_seen++;
        end
        check("rst_strobe", strobe_seen, 0);
        check("rst_sample", 32'(dac_sample), 0);
        check("rst_rdrst", 32'(rdrst), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // 5: LUT points, both output codings
        for (int i = 0; i < 4; i++) begin
            lut_addr = pt_addr[i];
            @(negedge clk);
            check("lut_tc", 32'(lut_tc), 32'(pt_tc[i]));
            check("lut_ob", 32'(lut_ob), 32'(pt_ob[i]));
        end

        // 2 and 4: single frame, phase continuity tick by tick
        fork
            send_byte(8'hF0);
            begin
                sync_frame();
                expect_frame(8'hF0);
            end
        join
        idle_check();

        // 3: burst while transmitting, FIFO fills, sixth byte dropped, frames back to back
        fork
            begin
                send_byte(8'h01);
                repeat (12) @(negedge clk);
                for (int b = 2; b <= 6; b++) send_byte(8'(b));
                check("burst_full", 32'(fifo_full), 1);
                check("burst_ovf", 32'(overflow), 1);
            end
            begin
                sync_frame();
                for (int b = 1; b <= 5; b++) expect_frame(8'(b));
            end
        join
        idle_check();
        check("ovf_sticky", 32'(overflow), 1);
        check("drain_full", 32'(fifo_full), 0);

        // Idle mark tone, then back to silence
        wait_strobe();
        idle_mark   = 1'b1;
        model_phase = '0;
        for (int i = 0; i < 4; i++) begin
            wait_strobe();
            model_phase = model_phase + 24'(MARK);
            check("mark_phase", 32'(dut.phase_reg), 32'(model_phase));
            check("mark_sample", 32'(dac_sample), 32'(sine_ref(int'(model_phase[23:14]))));
        end
        idle_mark = 1'b0;
        idle_check();

        // 6: reset in the middle of a data bit
        send_byte(8'h3C);
        sync_frame();
        frame_pending = 1'b0;
        repeat (20) wait_strobe();
        check("mid_state_data", 32'(dut.state_reg), 32'(DATA));
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dut.state_reg), 32'(IDLE));
        check("abort_busy", 32'(busy), 0);
        check("abort_sample", 32'(dac_sample), 0);
        check("abort_ovf", 32'(overflow), 0);
        rst = 1'b0;
        fork
            send_byte(8'h5A);
            begin
                sync_frame();
                expect_frame(8'h5A);
            end
        join
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
